rr_arb_mux: RTL

- Parametrised N-input, SIZE-bit successor to the combinational select mux.
- Adds valid/ready handshakes on every input and on the output.
- Arbitration is selectable per cycle: round-robin or fixed priority.
- Output is registered with a one-entry buffer. Sits between multiple datapath producers (e.g. writeback sources, forwarding paths) and a single consumer that may stall.

---
 rtl/rr_arb_mux.sv | 75 +++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// N-input valid/ready arbiter-mux with round-robin or fixed-priority grant.
// The winning word lands in a one-entry output register that can stall.
module rr_arb_mux #(
    parameter int SIZE   = 16,
    parameter int NUM_IN = 3,
    localparam int SELW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic [NUM_IN-1:0]      in_valid,
    output logic [NUM_IN-1:0]      in_ready,
    input  logic [NUM_IN*SIZE-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIZE-1:0]        out_data,
    output logic [SELW-1:0]        out_src
);

    logic [SELW-1:0]   ptr;
    logic [SELW-1:0]   g;
    logic              found;
    logic [NUM_IN-1:0] grant;
    logic              free;
    logic              fire_in;
    logic [SIZE-1:0]   sel_data;
    logic [SELW-1:0]   ptr_next;
    int                idx;

    assign free    = !out_valid || out_ready;
    assign fire_in = free && found;

    // Scan from ptr (round-robin) or from 0 (fixed); first valid wins.
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = mode ? k : int'(ptr) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                g     = SELW'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found) grant[g] = 1'b1;
    end

    assign in_ready = grant & {NUM_IN{free && rst_n}};
    assign sel_data = in_data[int'(g)*SIZE +: SIZE];
    assign ptr_next = (g == SELW'(NUM_IN - 1)) ? '0 : g + SELW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else begin
            if (fire_in) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= g;
                if (!mode) ptr <= ptr_next;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
